// File: rtl/lot_pkg.sv
// Shared types and constants for the lot gate sensor decoder.
// Contents: lot_state_t (3-bit FSM state), 2-bit sensor codes {a,b}.
package lot_pkg;

  localparam int unsigned SENS_W  = 2;
  localparam int unsigned STATE_W = 3;

  // Sensor pair encoding {outer a, inner b}, 1 = beam blocked
  localparam logic [SENS_W-1:0] S_NONE = 2'b00;
  localparam logic [SENS_W-1:0] S_B    = 2'b01;
  localparam logic [SENS_W-1:0] S_A    = 2'b10;
  localparam logic [SENS_W-1:0] S_AB   = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    EN_A     = 3'd1,
    EN_AB    = 3'd2,
    EN_B     = 3'd3,
    EX_B     = 3'd4,
    EX_BA    = 3'd5,
    EX_A     = 3'd6,
    WAIT_CLR = 3'd7
  } lot_state_t;

endpackage

// File: rtl/lot_sensor_sync.sv
// Per-sensor input conditioning: SYNC_STAGES flop synchronizer, optionally
// followed by a debouncer (enabled by defining LOT_DEBOUNCE_EN).
// Ports:
//   i_clk   in  system clock
//   i_rst   in  asynchronous active-high reset
//   i_sens  in  raw sensor level, asynchronous to i_clk
//   o_sens  out conditioned sensor level
module lot_sensor_sync
  import lot_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sens,
  output logic o_sens
);

  // Elaboration-time parameter sanity
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("lot_sensor_sync: SYNC_STAGES must be >= 2");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("lot_sensor_sync: DB_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  // Synchronizer shift chain; oldest sample at the MSB
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_sens};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef LOT_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  // Output follows only after DB_CYCLES consecutive samples differing from it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else if (w_sync == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
      r_db  <= w_sync;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_sens = r_db;
`else
  assign o_sens = w_sync;
`endif

endmodule

// File: rtl/lot_sensor_fsm.sv
// Lot gate crossing decoder: turns the outer/inner photo-sensor sequence into
// single-cycle Increase (entry) / Decrease (exit) pulses and flags illegal jumps.
// Optional input debouncing: define LOT_DEBOUNCE_EN.
// Ports:
//   Clock     in  system clock
//   Reset     in  asynchronous active-high reset
//   SensA     in  outer sensor, 1 = blocked (asynchronous)
//   SensB     in  inner sensor, 1 = blocked (asynchronous)
//   Increase  out one-cycle pulse, entry completed
//   Decrease  out one-cycle pulse, exit completed
//   Error     out one-cycle pulse, illegal sensor transition
//   Busy      out level, FSM not in IDLE
module lot_sensor_fsm
  import lot_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic SensA,
  input  logic SensB,
  output logic Increase,
  output logic Decrease,
  output logic Error,
  output logic Busy
);

  logic              w_a;
  logic              w_b;
  logic [SENS_W-1:0] w_code;

  lot_sensor_sync #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_sync_a (
    .i_clk (Clock),
    .i_rst (Reset),
    .i_sens(SensA),
    .o_sens(w_a)
  );

  lot_sensor_sync #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_sync_b (
    .i_clk (Clock),
    .i_rst (Reset),
    .i_sens(SensB),
    .o_sens(w_b)
  );

  assign w_code = {w_a, w_b};

  lot_state_t r_state;
  lot_state_t w_next;
  logic       r_inc, r_dec, r_err, r_busy;
  logic       w_inc, w_dec, w_err;

  // State and pulse registers; pulses share the edge that commits the transition
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_inc   <= w_inc;
      r_dec   <= w_dec;
      r_err   <= w_err;
      r_busy  <= (w_next != IDLE);
    end
  end

  // Next-state decode; any code not listed for a crossing state is a two-bit jump
  always_comb begin
    w_next = r_state;
    w_inc  = 1'b0;
    w_dec  = 1'b0;
    w_err  = 1'b0;
    unique case (r_state)
      IDLE: begin
        case (w_code)
          S_A:     w_next = EN_A;
          S_B:     w_next = EX_B;
          S_AB:    begin w_next = WAIT_CLR; w_err = 1'b1; end
          default: w_next = IDLE;
        endcase
      end
      EN_A: begin
        case (w_code)
          S_AB:    w_next = EN_AB;
          S_NONE:  w_next = IDLE;
          S_A:     w_next = EN_A;
          default: begin w_next = WAIT_CLR; w_err = 1'b1; end
        endcase
      end
      EN_AB: begin
        case (w_code)
          S_B:     w_next = EN_B;
          S_A:     w_next = EN_A;
          S_AB:    w_next = EN_AB;
          default: begin w_next = WAIT_CLR; w_err = 1'b1; end
        endcase
      end
      EN_B: begin
        case (w_code)
          S_NONE:  begin w_next = IDLE; w_inc = 1'b1; end
          S_AB:    w_next = EN_AB;
          S_B:     w_next = EN_B;
          default: begin w_next = WAIT_CLR; w_err = 1'b1; end
        endcase
      end
      EX_B: begin
        case (w_code)
          S_AB:    w_next = EX_BA;
          S_NONE:  w_next = IDLE;
          S_B:     w_next = EX_B;
          default: begin w_next = WAIT_CLR; w_err = 1'b1; end
        endcase
      end
      EX_BA: begin
        case (w_code)
          S_A:     w_next = EX_A;
          S_B:     w_next = EX_B;
          S_AB:    w_next = EX_BA;
          default: begin w_next = WAIT_CLR; w_err = 1'b1; end
        endcase
      end
      EX_A: begin
        case (w_code)
          S_NONE:  begin w_next = IDLE; w_dec = 1'b1; end
          S_AB:    w_next = EX_BA;
          S_A:     w_next = EX_A;
          default: begin w_next = WAIT_CLR; w_err = 1'b1; end
        endcase
      end
      WAIT_CLR: begin
        if (w_code == S_NONE) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign Increase = r_inc;
  assign Decrease = r_dec;
  assign Error    = r_err;
  assign Busy     = r_busy;

endmodule

// File: tb/tb_lot_sensor_fsm.sv
// Scoreboard bench for lot_sensor_fsm (default build, SYNC_STAGES=2).
module tb_lot_sensor_fsm;

  logic clk;
  logic Reset;
  logic SensA, SensB;
  logic Increase, Decrease, Error, Busy;

  lot_sensor_fsm #(.SYNC_STAGES(2), .DB_CYCLES(4)) dut (
    .Clock   (clk),
    .Reset   (Reset),
    .SensA   (SensA),
    .SensB   (SensB),
    .Increase(Increase),
    .Decrease(Decrease),
    .Error   (Error),
    .Busy    (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit mon_en = 1'b0;
  int mon_cycle = 0;
  logic [3:0] exp_q [$];

  // Reference model: a crossing is a walk along a fixed code sequence.
  // dir 0 = idle, 1 = entering, 2 = exiting, 3 = jammed until clear.
  logic [1:0] seq_en [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0] seq_ex [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int m_dir = 0;
  int m_pos = 0;

  task automatic model_step(input logic [1:0] code, output logic [3:0] e);
    logic inc, dec, err;
    logic [1:0] s [4];
    inc = 0; dec = 0; err = 0;
    if (m_dir == 0) begin
      if (code == 2'b10)      begin m_dir = 1; m_pos = 1; end
      else if (code == 2'b01) begin m_dir = 2; m_pos = 1; end
      else if (code == 2'b11) begin m_dir = 3; err = 1; end
    end else if (m_dir == 3) begin
      if (code == 2'b00) m_dir = 0;
    end else begin
      s = (m_dir == 1) ? seq_en : seq_ex;
      if (code == s[m_pos]) begin
      end else if (code == s[(m_pos + 1) % 4]) begin
        m_pos++;
        if (m_pos == 4) begin
          inc = (m_dir == 1);
          dec = (m_dir == 2);
          m_dir = 0;
        end
      end else if (code == s[m_pos - 1]) begin
        m_pos--;
        if (m_pos == 0) m_dir = 0;
      end else begin
        m_dir = 3;
        err = 1;
      end
    end
    e = {inc, dec, err, (m_dir != 0)};
  endtask

  // Drive a code for n cycles and queue what the DUT must show for each
  task automatic apply(input logic [1:0] code, input int n);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      {SensA, SensB} = code;
      model_step(code, e);
      exp_q.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %b required %b", name, got, exp);
  endtask

  // Monitor: outputs after edge k reflect the input applied before edge k-2
  initial begin
    logic [3:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        mon_cycle++;
        got = {Increase, Decrease, Error, Busy};
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_underflow: cycle %0d got %b required queued entry", mon_cycle, got);
        end else begin
          e = exp_q.pop_front();
          if (got === e) passes++;
          else $display("FAIL sb cycle %0d {inc,dec,err,busy}: got %b required %b", mon_cycle, got, e);
        end
      end
    end
  end

  initial begin
    logic [1:0] cur;
    int incs, decs, errs;

    // Reset state
    Reset = 1'b1;
    {SensA, SensB} = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_outputs", {Increase, Decrease, Error, Busy}, 4'b0000);

    // Release and start the scoreboard; sync stages hold zero for two edges
    Reset = 1'b0;
    m_dir = 0; m_pos = 0;
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
    mon_en = 1'b1;
    apply(2'b00, 3);

    // Entry, exit, backout (twice), illegal then clean entry
    apply(2'b10, 3); apply(2'b11, 3); apply(2'b01, 3); apply(2'b00, 5);
    apply(2'b01, 3); apply(2'b11, 3); apply(2'b10, 3); apply(2'b00, 5);
    for (int r = 0; r < 2; r++) begin
      apply(2'b10, 3); apply(2'b11, 3); apply(2'b10, 3); apply(2'b00, 4);
    end
    apply(2'b10, 3); apply(2'b01, 3); apply(2'b11, 3); apply(2'b01, 2); apply(2'b00, 4);
    apply(2'b10, 3); apply(2'b11, 3); apply(2'b01, 3); apply(2'b00, 5);
    apply(2'b11, 2); apply(2'b00, 3);

    // Random walk: mostly single-sensor changes, occasional arbitrary jumps
    cur = 2'b00;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) < 9) cur = cur ^ (($urandom_range(1) == 0) ? 2'b01 : 2'b10);
      else cur = 2'($urandom_range(3));
      apply(cur, $urandom_range(1, 4));
    end
    apply(2'b00, 6);
    mon_en = 1'b0;
    exp_q.delete();

    // Asynchronous reset mid-crossing clears outputs without a clock edge
    {SensA, SensB} = 2'b10;
    repeat (4) @(negedge clk);
    check("busy_mid_entry", {Increase, Decrease, Error, Busy}, 4'b0001);
    #2 Reset = 1'b1;
    #1 check("async_reset_clear", {Increase, Decrease, Error, Busy}, 4'b0000);
    {SensA, SensB} = 2'b00;
    @(negedge clk);
    Reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset after final release drops the pending Increase
    {SensA, SensB} = 2'b10; repeat (3) @(negedge clk);
    {SensA, SensB} = 2'b11; repeat (3) @(negedge clk);
    {SensA, SensB} = 2'b01; repeat (3) @(negedge clk);
    check("busy_before_release", {Increase, Decrease, Error, Busy}, 4'b0001);
    {SensA, SensB} = 2'b00;
    @(posedge clk);
    #2 Reset = 1'b1;
    incs = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (Increase) incs++;
    end
    check("pending_pulse_dropped", {Busy, 3'(incs)}, 4'b0000);
    @(negedge clk);
    Reset = 1'b0;
    repeat (3) @(negedge clk);

    // Clean entry after reset still counts exactly once
    incs = 0; decs = 0; errs = 0;
    for (int p = 0; p < 4; p++) begin
      {SensA, SensB} = (p == 0) ? 2'b10 : (p == 1) ? 2'b11 : (p == 2) ? 2'b01 : 2'b00;
      repeat (p == 3 ? 6 : 3) begin
        @(posedge clk); #1;
        if (Increase) incs++;
        if (Decrease) decs++;
        if (Error) errs++;
      end
    end
    check("post_reset_entry_inc", 4'(incs), 4'd1);
    check("post_reset_entry_dec_err", 4'(decs + errs), 4'd0);
    check("post_reset_idle", {Increase, Decrease, Error, Busy}, 4'b0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
